// File: rtl/ripple_add_sub_pkg.sv
// Shared operation encodings for the ripple-carry adder/subtractor.
package ripple_add_sub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/ripple_add_sub_full_adder.sv
// Single-bit full-adder cell used as one link of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_add_sub.sv
// Registered WIDTH-bit ripple-carry adder/subtractor (A+B or A+~B+1).
// No handshake: an operation is accepted every cycle and its result appears one clock later.
module ripple_add_sub
    import ripple_add_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Choice,
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY,
    output logic             OVERFLOW
);

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    // Subtraction inverts B and injects the +1 as the chain's carry-in.
    assign sub      = (Choice == OP_SUB);
    assign b_eff    = B ^ {WIDTH{sub}};
    assign carry[0] = sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .a    (A[i]),
            .b    (b_eff[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RESULT   <= '0;
            CARRY    <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            RESULT   <= sum;
            CARRY    <= carry[WIDTH];
            OVERFLOW <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_ripple_add_sub.sv
// Self-checking bench for ripple_add_sub: directed cases, reset, random stream and exhaustive sweep.
module tb_ripple_add_sub;

    localparam int W  = 4;
    localparam int OW = W + 2;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         choice;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] last_exp;
    logic          have_last;
    int            check_cnt;
    int            pass_cnt;

    ripple_add_sub #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (a),
        .B        (b),
        .Choice   (choice),
        .RESULT   (result),
        .CARRY    (carry),
        .OVERFLOW (overflow)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference: {overflow, carry, result}
    function automatic logic [OW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                            input logic mc);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic         ov;
        be   = mc ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, mc};
        ov   = (ma[W-1] == be[W-1]) && (full[W-1] != ma[W-1]);
        return {ov, full[W], full[W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got ovf/carry/result=%b/%b/%h, expected %b/%b/%h",
                     tag, obs[OW-1], obs[OW-2], obs[W-1:0], exp[OW-1], exp[OW-2], exp[W-1:0]);
        end
    endtask

    // Drive one cycle of stimulus with a given expectation, then score it.
    task automatic apply_exp(input string tag, input logic r, input logic [W-1:0] ia,
                             input logic [W-1:0] ib, input logic ic, input logic [OW-1:0] e);
        logic [OW-1:0] got;
        rst    = r;
        a      = ia;
        b      = ib;
        choice = ic;
        exp_q.push_back(e);
        @(negedge clk);
        if (have_last) check({tag, "_hold"}, {overflow, carry, result}, last_exp);
        @(posedge clk);
        #1;
        got = {overflow, carry, result};
        if (exp_q.size() == 0) begin
            check({tag, "_empty_queue"}, got, ~got);
        end else begin
            last_exp  = exp_q.pop_front();
            have_last = 1'b1;
            check(tag, got, last_exp);
        end
    endtask

    task automatic apply(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic);
        apply_exp(tag, 1'b0, ia, ib, ic, model(ia, ib, ic));
    endtask

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        have_last = 1'b0;

        // reset with arbitrary operands
        apply_exp("reset0", 1'b1, 4'hA, 4'h7, 1'b0, '0);
        apply_exp("reset1", 1'b1, 4'h3, 4'hC, 1'b1, '0);

        // directed cases: expected {ovf, carry, result}
        apply_exp("add_6_5",   1'b0, 4'h6, 4'h5, 1'b0, {1'b1, 1'b0, 4'hB});
        apply_exp("sub_6_5",   1'b0, 4'h6, 4'h5, 1'b1, {1'b0, 1'b1, 4'h1});
        apply_exp("add_4_1",   1'b0, 4'h4, 4'h1, 1'b0, {1'b0, 1'b0, 4'h5});
        apply_exp("sub_4_1",   1'b0, 4'h4, 4'h1, 1'b1, {1'b0, 1'b1, 4'h3});
        apply_exp("add_e_5",   1'b0, 4'hE, 4'h5, 1'b0, {1'b0, 1'b1, 4'h3});
        apply_exp("sub_e_5",   1'b0, 4'hE, 4'h5, 1'b1, {1'b0, 1'b1, 4'h9});
        apply_exp("sub_borrow",1'b0, 4'h1, 4'h2, 1'b1, {1'b0, 1'b0, 4'hF});
        apply_exp("add_wrap",  1'b0, 4'hF, 4'h1, 1'b0, {1'b0, 1'b1, 4'h0});
        apply_exp("sub_equal", 1'b0, 4'h7, 4'h7, 1'b1, {1'b0, 1'b1, 4'h0});
        apply_exp("sub_zero",  1'b0, 4'hC, 4'h0, 1'b1, {1'b0, 1'b1, 4'hC});
        apply_exp("sub_ovf",   1'b0, 4'h8, 4'h1, 1'b1, {1'b1, 1'b1, 4'h7});

        // reset wins over operands in the same cycle
        apply("pre_reset", 4'h2, 4'h3, 1'b0);
        apply_exp("reset_9_9", 1'b1, 4'h9, 4'h9, 1'b0, '0);
        apply("post_reset", 4'h9, 4'h9, 1'b0);

        // back-to-back random stream, choice toggling freely
        for (int i = 0; i < 40; i++) begin
            apply("random", W'($urandom_range(0, (1 << W) - 1)),
                  W'($urandom_range(0, (1 << W) - 1)), 1'($urandom_range(0, 1)));
        end

        // exhaustive sweep
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < (1 << W); i++) begin
                for (int j = 0; j < (1 << W); j++) begin
                    apply("sweep", W'(i), W'(j), 1'(c));
                end
            end
        end

        if (exp_q.size() != 0) begin
            check_cnt++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/ripple_add_sub.md
Name: ripple_add_sub

Overview:
- Registered N-bit ripple-carry adder/subtractor with a single-bit operation select.
- Choice=0 computes A+B; Choice=1 computes A-B as A + ~B + 1 (two's complement).
- Intended as a small arithmetic leaf block in datapaths, and as a teaching/reference ripple-carry structure.
- Built from a chain of 1-bit full-adder cells, with output registers on one clock.

Parameters:
- WIDTH, 4, operand and result width in bits (must be >= 1).

Ports:
- clk       input   1      sole clock; all state updates on rising edge
- rst       input   1      synchronous reset, active-high
- A         input   WIDTH  operand A (unsigned or two's complement)
- B         input   WIDTH  operand B
- Choice    input   1      operation select: 0 = A+B, 1 = A-B
- RESULT    output  WIDTH  registered sum/difference, low WIDTH bits
- CARRY     output  1      registered carry-out of the MSB cell
- OVERFLOW  output  1      registered signed-overflow flag

Behaviour:
- Reset: on a rising clk edge with rst=1, RESULT=0, CARRY=0, OVERFLOW=0.
  - Reset has priority over new operands.
  - Reset asserted mid-stream discards the pending result.
- Datapath (combinational):
  - Per bit, b_eff[i] = B[i] XOR Choice.
  - Carry-in to bit 0 = Choice.
  - Each cell: s = a^b^cin; cout = (a&b)|(cin&(a^b)).
  - The carry ripples from bit 0 to bit WIDTH-1.
- Outputs:
  - Every non-reset rising edge registers RESULT = s[WIDTH-1:0] and CARRY = carry-out of bit WIDTH-1.
  - OVERFLOW = carry into MSB XOR carry out of MSB.
- Latency: exactly 1 clock, from A/B/Choice sampled at edge k to outputs visible after edge k.
  - No handshake; a new operation is accepted every cycle.
- Arithmetic rules:
  - Addition: CARRY=1 means the unsigned sum exceeded 2^WIDTH-1. RESULT wraps modulo 2^WIDTH.
  - Subtraction: CARRY=1 means no borrow (unsigned A >= B); CARRY=0 means borrow (A < B). RESULT is the two's-complement difference modulo 2^WIDTH.
  - Subtracting B=0 gives RESULT=A and CARRY=1.
  - A=B under subtraction gives RESULT=0 and CARRY=1.
- Choice is sampled with the operands; changing Choice between cycles has no cross-cycle effect.
- No X-propagation masking: outputs follow the inputs on the next edge.

Decomposition:
- Shared package holds the operation encodings: OP_ADD = 1'b0, OP_SUB = 1'b1.
- No typedefs are required.
- One natural sub-module: full_adder (inputs a, b, cin; outputs s, cout), instantiated WIDTH times via a generate loop with the carry chained.
- The XOR-invert stage and the output registers live in ripple_add_sub.

Test Plan (WIDTH=4, values hex, check one cycle after applying):
- rst=1 for 2 cycles with arbitrary inputs -> RESULT=0, CARRY=0, OVERFLOW=0. Deassert rst; first valid result appears after the next edge.
- A=6, B=5, Choice=0 -> RESULT=B, CARRY=0, OVERFLOW=1. Same operands, Choice=1 -> RESULT=1, CARRY=1, OVERFLOW=0.
- A=4, B=1, Choice=0 -> RESULT=5, CARRY=0. Same operands, Choice=1 -> RESULT=3, CARRY=1.
- A=E, B=5, Choice=0 -> RESULT=3, CARRY=1 (unsigned wrap). Same operands, Choice=1 -> RESULT=9, CARRY=1.
- Borrow and boundaries:
  - A=1, B=2, Choice=1 -> RESULT=F, CARRY=0.
  - A=F, B=1, Choice=0 -> RESULT=0, CARRY=1.
  - A=7, B=7, Choice=1 -> RESULT=0, CARRY=1.
- Back-to-back plus reset:
  - Change operands every cycle; each result lags by exactly one cycle.
  - Assert rst in the same cycle as A=9, B=9 -> outputs 0, not 2.
  - Then run an exhaustive 4-bit sweep against a reference model.
